// File: rtl/delay_timer_arbiter_if.sv
// Request/grant bundle between the shared delay timer and its requesting FSMs.
// master = requester side, slave = the timer arbiter.
interface delay_timer_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] delay;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [ID_W-1:0]          cur_id;

  modport master (
    output req, delay,
    input  grant, done, busy, cur_id
  );

  modport slave (
    input  req, delay,
    output grant, done, busy, cur_id
  );
endinterface

// File: rtl/delay_timer_arbiter.sv
// One down-counting delay timer shared round-robin among NUM_REQ requesters.
// Define TIMER_PRESCALE_EN to make each tick last PRESCALE_DIV clocks instead of one.
module delay_timer_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CNT_W        = 16,
  parameter int PRESCALE_DIV = 100000
) (
  input logic                   clk,
  input logic                   reset,
  delay_timer_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    cur_q, cur_d;

  logic               tick;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [CNT_W-1:0]   pick_delay;
  int                 scan_idx;

`ifdef TIMER_PRESCALE_EN
  localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

  logic [PRE_W-1:0] pre_q;

  // Prescaler restarts from zero at every grant because it idles at zero outside COUNT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else if (state_q != COUNT || pre_q == PRE_LAST) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  assign tick = (pre_q == PRE_LAST);
`else
  localparam int unused_prescale_div = PRESCALE_DIV;

  assign tick = 1'b1;
`endif

  // Round-robin pick: first asserted request after the last served requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(cur_q) + k) % NUM_REQ;
      if (!pick_found && bus.req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(scan_idx);
      end
    end
    pick_delay = bus.delay[int'(pick_idx)*CNT_W +: CNT_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          cur_d   = pick_idx;
          cnt_d   = pick_delay;
          busy_d  = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            done_d  = NUM_REQ'(1) << cur_q;
            grant_d = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      cur_q   <= LAST_ID;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cur_q   <= cur_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.cur_id = cur_q;
endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Bench for delay_timer_arbiter: timeline-based reference model compared every cycle,
// directed services with literal expectations, then randomized requesters.
module tb_delay_timer_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic clk = 1'b0;
  logic reset;

  delay_timer_arbiter_if #(.NUM_REQ(N), .CNT_W(W)) bus ();

  delay_timer_arbiter #(.NUM_REQ(N), .CNT_W(W), .PRESCALE_DIV(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int   edge_n   = 0;
  bit   m_active = 1'b0;
  int   m_id     = 0;
  int   m_start  = 0;
  int   m_d      = 0;
  int   m_last   = N - 1;
  int   m_idx    = 0;
  bit   m_found  = 1'b0;
  int   m_off    = 0;
  logic [N-1:0] exp_grant = '0;
  logic [N-1:0] exp_done  = '0;
  logic         exp_busy  = 1'b0;
  logic [1:0]   exp_cur   = 2'd3;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
  endtask

  // Each service occupies a fixed window after its grant edge: (D+1)*P cycles granted,
  // one cycle of done, then one idle edge before the next grant can happen.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      edge_n   = 0;
      m_active = 1'b0;
      m_last   = N - 1;
    end else begin
      edge_n++;
      if (m_active) begin
        if (edge_n - m_start == (m_d + 1) * P + 1) m_active = 1'b0;
      end else if (bus.req != '0) begin
        m_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          m_idx = (m_last + k) % N;
          if (!m_found && bus.req[m_idx]) begin
            m_found = 1'b1;
            m_id    = m_idx;
          end
        end
        m_active = 1'b1;
        m_start  = edge_n;
        m_d      = int'(bus.delay[m_id*W +: W]);
        m_last   = m_id;
      end
    end
    exp_grant = '0;
    exp_done  = '0;
    exp_busy  = m_active;
    exp_cur   = 2'(m_last);
    if (m_active) begin
      m_off = edge_n - m_start;
      if (m_off < (m_d + 1) * P) exp_grant = N'(1) << m_id;
      if (m_off == (m_d + 1) * P) exp_done = N'(1) << m_id;
    end
  end

  initial forever begin
    @(negedge clk);
    check_output("model_grant", 32'(bus.grant), 32'(exp_grant));
    check_output("model_done", 32'(bus.done), 32'(exp_done));
    check_output("model_busy", 32'(bus.busy), 32'(exp_busy));
    check_output("model_cur_id", 32'(bus.cur_id), 32'(exp_cur));
  end

  task automatic reset_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // Serve a lone requester; optionally rewrite its delay mid-count to show it is ignored.
  task automatic serve_one(input int idx, input int d, input int chg_at, input int chg_d);
    int total;
    total = (d + 1) * P;
    bus.req[idx] = 1'b1;
    bus.delay[idx*W +: W] = W'(d);
    for (int k = 0; k <= total + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check_output("lit_grant_start", 32'(bus.grant), 32'(N'(1) << idx));
        check_output("lit_cur_id", 32'(bus.cur_id), 32'(idx));
      end
      if (k == chg_at) bus.delay[idx*W +: W] = W'(chg_d);
      if (k == total - 1) check_output("lit_no_early_done", 32'(bus.done), 32'h0);
      if (k == total) begin
        check_output("lit_done", 32'(bus.done), 32'(N'(1) << idx));
        check_output("lit_grant_dropped", 32'(bus.grant), 32'h0);
        #1 bus.req[idx] = 1'b0;
      end
      if (k == total + 1) begin
        check_output("lit_busy_low", 32'(bus.busy), 32'h0);
        check_output("lit_done_clear", 32'(bus.done), 32'h0);
      end
    end
  endtask

  function automatic logic [W-1:0] rand_delay();
    if ($urandom_range(0, 31) == 0) return W'($urandom_range(0, 255));
    return W'($urandom_range(0, 7));
  endfunction

  task automatic apply_stimulus();
    for (int i = 0; i < N; i++) begin
      if (exp_done[i]) begin
        if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
      end else if (!bus.req[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.req[i] = 1'b1;
          bus.delay[i*W +: W] = rand_delay();
        end
      end else if ($urandom_range(0, 63) == 0) begin
        bus.req[i] = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) bus.delay[i*W +: W] = rand_delay();
    end
  endtask

  initial begin
    int period;
    reset     = 1'b1;
    bus.req   = '0;
    bus.delay = '0;

    repeat (5) begin
      @(negedge clk);
      check_output("rst_grant", 32'(bus.grant), 32'h0);
      check_output("rst_done", 32'(bus.done), 32'h0);
      check_output("rst_busy", 32'(bus.busy), 32'h0);
      check_output("rst_cur_id", 32'(bus.cur_id), 32'h3);
    end
    #2 reset = 1'b0;

    serve_one(0, 5, -1, 0);
    serve_one(1, 0, -1, 0);
    serve_one(2, 255, -1, 0);
    serve_one(3, 6, 2, 3);
`ifdef TIMER_PRESCALE_EN
    serve_one(1, 3, -1, 0);
`endif

    // All four request at once: strict order 0,1,2,3.
    reset_pulse();
    period = 3 * P + 2;
    for (int i = 0; i < N; i++) bus.delay[i*W +: W] = W'(2);
    bus.req = 4'b1111;
    for (int t = 0; t < 4 * period; t++) begin
      @(negedge clk);
      if (t % period == 0) check_output("rr_order", 32'(bus.grant), 32'(4'b0001 << (t / period)));
      if (t % period == 3 * P) #1 bus.req[t / period] = 1'b0;
    end

    // Requester 0 never releases: it must alternate with requester 2.
    reset_pulse();
    period = 2 * P + 2;
    bus.delay[0*W +: W] = W'(1);
    bus.delay[2*W +: W] = W'(1);
    bus.req = 4'b0101;
    for (int t = 0; t < 4 * period; t++) begin
      @(negedge clk);
      if (t % period == 0)
        check_output("rr_alternate", 32'(bus.grant), ((t / period) % 2 == 0) ? 32'h1 : 32'h4);
    end
    bus.req = '0;
    repeat (2 * period) @(negedge clk);

    // Reset three edges into a delay-10 service.
    reset_pulse();
    bus.delay[0*W +: W] = W'(10);
    bus.req[0] = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("abort_grant", 32'(bus.grant), 32'h0);
    check_output("abort_busy", 32'(bus.busy), 32'h0);
    check_output("abort_cur_id", 32'(bus.cur_id), 32'h3);
    bus.req = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    for (int t = 0; t < 14 * P; t++) begin
      @(negedge clk);
      check_output("abort_no_done", 32'(bus.done), 32'h0);
    end

    reset_pulse();
    repeat (3000) begin
      @(negedge clk);
      #1 apply_stimulus();
    end
    bus.req = '0;
    repeat (260 * P + 10) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
